// File: rtl/aes_pkg.sv
// Shared AES constants, byte-lane index helper and the FIPS-197 inverse S-box table.
// Byte k of a 128-bit state is the k-th byte from the MSB end.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_NBYTES  = 16;
    localparam int AES_IDX_W   = $clog2(AES_STATE_W);

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_RUN  = 1'b1
    } sb_state_e;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // MSB bit position of byte k, for use with a "-: 8" part-select.
    function automatic logic [AES_IDX_W-1:0] byte_msb(input int k);
        return AES_IDX_W'(AES_STATE_W - 1 - 8 * k);
    endfunction

    function automatic logic [7:0] inv_sbox_lut(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Single-byte combinational inverse S-box lookup.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    assign byte_o = inv_sbox_lut(byte_i);

endmodule

// File: rtl/inv_subbytes_seq.sv
// Iterative AES InvSubBytes: BYTES_PER_CYCLE shared inverse S-boxes rewrite the state
// register in place, MSB byte first, with a start/done handshake for the round controller.
module inv_subbytes_seq
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [AES_STATE_W-1:0] state_in,
    output logic [AES_STATE_W-1:0] state_out,
    output logic                   busy,
    output logic                   done_sb
);

    localparam int N_STEPS = AES_NBYTES / BYTES_PER_CYCLE;
    localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_STEPS - 1);

    sb_state_e              fsm_q, fsm_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [AES_STATE_W-1:0] st_q, st_d;
    logic                   done_q, done_d;
    logic                   last_step;
    logic [7:0]             lane_in  [BYTES_PER_CYCLE];
    logic [7:0]             lane_out [BYTES_PER_CYCLE];

    assign last_step = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q  <= SB_IDLE;
            cnt_q  <= '0;
            st_q   <= '0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            SB_IDLE: if (start)     fsm_d = SB_RUN;
            SB_RUN:  if (last_step) fsm_d = SB_IDLE;
            default:                fsm_d = SB_IDLE;
        endcase
    end

    // Lane l of step s reads byte s*BYTES_PER_CYCLE + l.
    always_comb begin
        for (int l = 0; l < BYTES_PER_CYCLE; l++) lane_in[l] = '0;
        for (int s = 0; s < N_STEPS; s++) begin
            if (cnt_q == CNT_W'(s)) begin
                for (int l = 0; l < BYTES_PER_CYCLE; l++)
                    lane_in[l] = st_q[byte_msb(s * BYTES_PER_CYCLE + l) -: 8];
            end
        end
    end

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
        inv_sbox u_sbox (
            .byte_i (lane_in[g]),
            .byte_o (lane_out[g])
        );
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        case (fsm_q)
            SB_IDLE: begin
                if (start) begin
                    st_d  = state_in;
                    cnt_d = '0;
                end
            end
            SB_RUN: begin
                for (int s = 0; s < N_STEPS; s++) begin
                    if (cnt_q == CNT_W'(s)) begin
                        for (int l = 0; l < BYTES_PER_CYCLE; l++)
                            st_d[byte_msb(s * BYTES_PER_CYCLE + l) -: 8] = lane_out[l];
                    end
                end
                cnt_d  = last_step ? '0 : cnt_q + CNT_W'(1);
                done_d = last_step;
            end
            default: ;
        endcase
    end

    assign state_out = st_q;
    assign busy      = (fsm_q == SB_RUN);
    assign done_sb   = done_q;

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Bench for inv_subbytes_seq at BYTES_PER_CYCLE = 1, 4 and 16 side by side, against a
// transaction model whose inverse S-box is derived from GF(2^8) arithmetic.
module tb_inv_subbytes_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] state_in;
    logic [127:0] so [3];
    logic         bz [3];
    logic         dn [3];

    always #5 clk = ~clk;

    inv_subbytes_seq #(.BYTES_PER_CYCLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
        .state_out(so[0]), .busy(bz[0]), .done_sb(dn[0]));
    inv_subbytes_seq #(.BYTES_PER_CYCLE(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
        .state_out(so[1]), .busy(bz[1]), .done_sb(dn[1]));
    inv_subbytes_seq #(.BYTES_PER_CYCLE(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .state_in(state_in),
        .state_out(so[2]), .busy(bz[2]), .done_sb(dn[2]));

    logic [7:0]   mtab [256];
    int           rem [3];
    logic [127:0] orig [3];
    logic [127:0] idle_out [3];
    bit           exp_done [3];
    int           lat [3];
    int           n_tests = 0;
    int           n_fail  = 0;
    bit           chk_en  = 1'b0;

    function automatic int bpc(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            default: return 16;
        endcase
    endfunction

    function automatic int nsteps(input int i);
        return 16 / bpc(i);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Inverse S-box = GF(2^8) inverse of the inverse affine transform.
    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] t, y;
            t = 8'(x);
            t = rotl(t, 1) ^ rotl(t, 3) ^ rotl(t, 6) ^ 8'h05;
            y = 8'h00;
            if (t != 8'h00)
                for (int c = 1; c < 256; c++)
                    if (gmul(t, 8'(c)) == 8'h01) y = 8'(c);
            mtab[x] = y;
        end
    end

    // Substitute the first nbytes bytes (MSB first) of s.
    function automatic logic [127:0] subst_first(input logic [127:0] s, input int nbytes);
        logic [127:0] r;
        logic [7:0]   bv;
        int           sh;
        r = s;
        for (int b = 0; b < 16; b++) begin
            if (b < nbytes) begin
                sh = 8 * (15 - b);
                bv = 8'(s >> sh);
                r  = (r & ~(128'hFF << sh)) | (128'(mtab[bv]) << sh);
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                rem[i]      = 0;
                exp_done[i] = 1'b0;
                idle_out[i] = '0;
            end else if (rem[i] > 0) begin
                rem[i]      = rem[i] - 1;
                exp_done[i] = (rem[i] == 0);
                if (rem[i] == 0) idle_out[i] = subst_first(orig[i], 16);
            end else begin
                exp_done[i] = 1'b0;
                if (start) begin
                    orig[i] = state_in;
                    rem[i]  = nsteps(i);
                end
            end
        end
    end

    task automatic check_vec(input string name, input int i, input logic [127:0] got,
                             input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d (bpc=%0d) t=%0t: got %h, expected %h",
                     name, i, (i < 0) ? 0 : bpc(i), $time, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int i, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d (bpc=%0d): got %0d, expected %0d", name, i, bpc(i), got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check_vec("busy", i, 128'(bz[i]), 128'(rem[i] > 0));
                check_vec("done_sb", i, 128'(dn[i]), 128'(exp_done[i]));
                check_vec("state_out", i, so[i],
                          (rem[i] > 0) ? subst_first(orig[i], (nsteps(i) - rem[i]) * bpc(i))
                                       : idle_out[i]);
            end
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input logic s, input logic [127:0] d);
        start    = s;
        state_in = d;
    endtask

    task automatic start_measure(input logic [127:0] d);
        for (int i = 0; i < 3; i++) lat[i] = 0;
        drive(1'b1, d);
        tick();
        drive(1'b0, rand128());
        for (int k = 2; k <= 40; k++) begin
            tick();
            for (int i = 0; i < 3; i++)
                if (lat[i] == 0 && dn[i]) lat[i] = k;
        end
        for (int i = 0; i < 3; i++) check_int("latency", i, lat[i], nsteps(i) + 1);
    endtask

    task automatic check_all_out(input string name, input logic [127:0] exp);
        for (int i = 0; i < 3; i++) check_vec(name, i, so[i], exp);
    endtask

    initial begin
        int cnt0, cnt1, k;
        int ndone [3];
        rst_n = 1'b0;
        drive(1'b1, rand128());
        @(posedge clk);
        chk_en = 1'b1;

        check_vec("pin_63", -1, 128'(mtab[8'h63]), 128'h00);
        check_vec("pin_00", -1, 128'(mtab[8'h00]), 128'h52);
        check_vec("pin_01", -1, 128'(mtab[8'h01]), 128'h09);
        check_vec("pin_7C", -1, 128'(mtab[8'h7C]), 128'h01);
        check_vec("pin_FF", -1, 128'(mtab[8'hFF]), 128'h7D);

        // reset held with start asserted
        for (int r = 0; r < 3; r++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                check_vec("rst_state_out", i, so[i], '0);
                check_vec("rst_busy", i, 128'(bz[i]), '0);
                check_vec("rst_done", i, 128'(dn[i]), '0);
            end
        end
        rst_n = 1'b1;
        drive(1'b0, '0);
        tick();

        start_measure({16{8'h63}});
        check_all_out("vec_63", '0);
        start_measure({16{8'h00}});
        check_all_out("vec_00", {16{8'h52}});

        start_measure({8'h00, 8'h01, 8'h7C, 8'hFF, {12{8'h00}}});
        check_all_out("byte_order", {8'h52, 8'h09, 8'h01, 8'h7D, {12{8'h52}}});

        // start re-asserted with new data on every RUN cycle
        drive(1'b1, {16{8'h00}});
        tick();
        for (int r = 0; r < 3; r++) begin
            drive(1'b1, rand128());
            tick();
        end
        drive(1'b0, rand128());
        cnt0 = 0; cnt1 = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (dn[0]) cnt0++;
            if (dn[1]) cnt1++;
        end
        check_int("busy_done_count", 0, cnt0, 1);
        check_int("busy_done_count", 1, cnt1, 1);
        check_vec("busy_ignored", 0, so[0], {16{8'h52}});
        check_vec("busy_ignored", 1, so[1], {16{8'h52}});

        // back-to-back: new start in the done_sb cycle
        drive(1'b1, rand128());
        tick();
        drive(1'b0, rand128());
        k = 0;
        while (!dn[1] && k < 20) begin
            tick();
            k++;
        end
        check_int("b2b_first_done", 1, int'(dn[1]), 1);
        drive(1'b1, {16{8'hFF}});
        tick();
        drive(1'b0, rand128());
        lat[1] = 0;
        for (int c = 2; c <= 20; c++) begin
            tick();
            if (lat[1] == 0 && dn[1]) lat[1] = c;
        end
        check_int("b2b_latency", 1, lat[1], 5);
        repeat (20) tick();
        check_vec("b2b_result", 1, so[1], {16{8'h7D}});
        check_vec("b2b_result", 2, so[2], {16{8'h7D}});

        // abort with reset at cnt=2
        drive(1'b1, rand128());
        tick();
        drive(1'b0, rand128());
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check_vec("abort_state_out", i, so[i], '0);
            check_vec("abort_busy", i, 128'(bz[i]), '0);
            check_vec("abort_done", i, 128'(dn[i]), '0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) ndone[i] = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int i = 0; i < 3; i++) if (dn[i]) ndone[i]++;
        end
        for (int i = 0; i < 3; i++) check_int("abort_no_done", i, ndone[i], 0);
        start_measure({16{8'h7C}});
        check_all_out("after_abort", {16{8'h01}});

        // start held high, fresh random state every cycle
        for (int c = 0; c < 18000; c++) begin
            drive(1'b1, rand128());
            tick();
        end

        // sparse random starts with occasional resets
        for (int c = 0; c < 2000; c++) begin
            rst_n = ($urandom_range(149) != 0);
            drive(($urandom_range(2) == 0), rand128());
            tick();
        end
        rst_n = 1'b1;
        drive(1'b0, '0);
        repeat (40) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
